// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack bus and
// presents if_pc/if_inst to the IF/ID register, with a skid buffer for stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  output logic              ibus_req,
  output logic [31:0]       ibus_addr,
  input  logic [DATA_W-1:0] ibus_rdata,
  input  logic              ibus_ack,
  output logic              ce,
  output logic [31:0]       if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_from_if
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DROP} state_t;

  state_t            state, state_nx;
  logic [31:0]       pc, pc_nx;
  logic [31:0]       addr_q, addr_nx;
  logic [DATA_W-1:0] inst_buf, buf_nx;
  logic [31:0]       next_pc_raw, next_pc, flush_pc;
  logic              unused_stall;

  // Only the PC-hold bit matters here; the other bits belong to later stages.
  assign unused_stall = ^stall[5:1];

  assign next_pc_raw = branch_flag_i ? branch_target_i : pc + 32'd4;
  assign next_pc     = {next_pc_raw[31:2], 2'b00};
  assign flush_pc    = {new_pc[31:2], 2'b00};
  assign ibus_addr   = addr_q;

  always_comb begin
    state_nx         = state;
    pc_nx            = pc;
    addr_nx          = addr_q;
    buf_nx           = inst_buf;
    ibus_req         = 1'b0;
    ce               = 1'b1;
    if_pc            = '0;
    if_inst          = '0;
    stallreq_from_if = 1'b0;
    case (state)
      S_IDLE: begin
        ce       = 1'b0;
        state_nx = S_BUSY;
        if (flush) begin
          pc_nx   = flush_pc;
          addr_nx = flush_pc;
        end else begin
          addr_nx = pc;
        end
      end
      S_BUSY: begin
        ibus_req = 1'b1;
        if (ibus_ack) begin
          if_inst = ibus_rdata;
          if_pc   = pc;
          if (flush) begin
            pc_nx   = flush_pc;
            addr_nx = flush_pc;
          end else if (!stall[0]) begin
            pc_nx   = next_pc;
            addr_nx = next_pc;
          end else begin
            buf_nx   = ibus_rdata;
            state_nx = S_HOLD;
          end
        end else begin
          stallreq_from_if = 1'b1;
          // Address must stay put until the slave acks; remember the target only.
          if (flush) begin
            pc_nx    = flush_pc;
            state_nx = S_DROP;
          end
        end
      end
      S_HOLD: begin
        if_inst = inst_buf;
        if_pc   = pc;
        if (flush) begin
          pc_nx    = flush_pc;
          addr_nx  = flush_pc;
          state_nx = S_BUSY;
        end else if (!stall[0]) begin
          pc_nx    = next_pc;
          addr_nx  = next_pc;
          state_nx = S_BUSY;
        end
      end
      S_DROP: begin
        ibus_req         = 1'b1;
        stallreq_from_if = 1'b1;
        if (ibus_ack) begin
          state_nx = S_BUSY;
          if (flush) begin
            pc_nx   = flush_pc;
            addr_nx = flush_pc;
          end else begin
            addr_nx = pc;
          end
        end else if (flush) begin
          pc_nx = flush_pc;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= {RESET_PC[31:2], 2'b00};
      addr_q   <= {RESET_PC[31:2], 2'b00};
      inst_buf <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      addr_q   <= addr_nx;
      inst_buf <= buf_nx;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random
// bus/stall/flush traffic against a behavioural fetch model.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata = '0;
  logic        ibus_ack = 1'b0;
  logic        ce;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;
  logic [98:0] actv;

  int total = 0;
  int bad = 0;

  // Model: "started", "discarding a stale access", "holding a stalled word".
  bit          m_run = 1'b0, m_drop = 1'b0, m_hold = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_addr = RESET_PC, m_buf = '0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata),
    .ibus_ack(ibus_ack), .ce(ce), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_from_if(stallreq_from_if)
  );

  always #5 clk = ~clk;

  assign actv = {ibus_req, ce, stallreq_from_if, ibus_addr, if_pc, if_inst};

  function automatic logic [31:0] al(input logic [31:0] x);
    return {x[31:2], 2'b00};
  endfunction

  // Expected {req, ce, stallreq, addr, if_pc, if_inst} for the current inputs.
  function automatic logic [98:0] expv();
    logic r, c, s;
    logic [31:0] p, i;
    r = 1'b0; c = 1'b0; s = 1'b0; p = '0; i = '0;
    if (m_run) begin
      c = 1'b1;
      if (m_hold) begin
        p = m_pc; i = m_buf;
      end else begin
        r = 1'b1;
        if (!m_drop && ibus_ack) begin
          p = m_pc; i = ibus_rdata;
        end else begin
          s = 1'b1;
        end
      end
    end
    return {r, c, s, m_addr, p, i};
  endfunction

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic [5:0] st, input logic f, input logic [31:0] np,
                       input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; ibus_ack = a; ibus_rdata = d; stall = st; flush = f;
    new_pc = np; branch_flag_i = b; branch_target_i = t;
    #1;
  endtask

  task automatic step();
    logic [31:0] nx, np;
    @(posedge clk);
    nx = al(branch_flag_i ? branch_target_i : m_pc + 32'd4);
    np = al(new_pc);
    if (rst) begin
      m_run = 0; m_drop = 0; m_hold = 0;
      m_pc = RESET_PC; m_addr = RESET_PC; m_buf = '0;
    end else if (!m_run) begin
      m_run = 1;
      if (flush) begin m_pc = np; m_addr = np; end
      else m_addr = m_pc;
    end else if (m_hold) begin
      if (flush) begin m_pc = np; m_addr = np; m_hold = 0; end
      else if (!stall[0]) begin m_pc = nx; m_addr = nx; m_hold = 0; end
    end else if (m_drop) begin
      if (ibus_ack) begin
        m_drop = 0;
        if (flush) begin m_pc = np; m_addr = np; end
        else m_addr = m_pc;
      end else if (flush) begin
        m_pc = np;
      end
    end else if (ibus_ack) begin
      if (flush) begin m_pc = np; m_addr = np; end
      else if (!stall[0]) begin m_pc = nx; m_addr = nx; end
      else begin m_buf = ibus_rdata; m_hold = 1; end
    end else if (flush) begin
      m_pc = np; m_drop = 1;
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 32'hdead_beef, '0, 0, '0, 0, '0);
    step();
    drive(1, 1, 32'hdead_beef, '0, 0, '0, 0, '0);
    total++;
    if ({ibus_req, ce, stallreq_from_if, if_pc, if_inst} !== 67'd0 || ibus_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_outputs actual=%h required=req/ce/stallreq/pc/inst=0 addr=%h", actv, RESET_PC);
    end
    step();
  endtask

  task automatic test_zero_wait();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_req !== 1'b0) begin
      bad++; $display("FAIL idle_cycle actual=%h required=%h", actv, expv());
    end
    step();
    for (int unsigned k = 0; k < 4; k++) begin
      drive(0, 1, $urandom, '0, 0, '0, 0, '0);
      total++;
      if (actv !== expv() || ibus_addr !== 32'(k * 4) || if_pc !== 32'(k * 4) ||
          stallreq_from_if !== 1'b0) begin
        bad++; $display("FAIL zero_wait_%0d actual=%h required=%h", k, actv, expv());
      end
      step();
    end
  endtask

  task automatic test_wait_state();
    logic [31:0] w;
    drive(1, 0, '0, '0, 0, '0, 0, '0); step();
    drive(0, 1, '0, '0, 0, '0, 0, '0); step();
    for (int unsigned k = 0; k < 2; k++) begin
      drive(0, 1, $urandom, '0, 0, '0, 0, '0); step();
    end
    for (int unsigned k = 0; k < 2; k++) begin
      drive(0, 0, $urandom, 6'b000011, 0, '0, 0, '0);
      total++;
      if (actv !== expv() || ibus_req !== 1'b1 || ibus_addr !== 32'h8 ||
          stallreq_from_if !== 1'b1 || if_inst !== '0) begin
        bad++; $display("FAIL wait_%0d actual=%h required=%h", k, actv, expv());
      end
      step();
    end
    w = $urandom;
    drive(0, 1, w, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || if_inst !== w || if_pc !== 32'h8 || stallreq_from_if !== 1'b0) begin
      bad++; $display("FAIL wait_ack actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0); step();
  endtask

  task automatic test_hold();
    logic [31:0] w;
    w = $urandom;
    drive(0, 1, w, 6'b000111, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h10 || if_inst !== w) begin
      bad++; $display("FAIL hold_enter actual=%h required=%h", actv, expv());
    end
    step();
    for (int unsigned k = 0; k < 2; k++) begin
      drive(0, 0, $urandom, 6'b000111, 0, '0, 0, '0);
      total++;
      if (actv !== expv() || ibus_req !== 1'b0 || if_inst !== w || if_pc !== 32'h10) begin
        bad++; $display("FAIL hold_%0d actual=%h required=%h", k, actv, expv());
      end
      step();
    end
    drive(0, 0, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || if_inst !== w) begin
      bad++; $display("FAIL hold_release actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h14 || ibus_req !== 1'b1) begin
      bad++; $display("FAIL hold_next actual=%h required=addr 00000014", actv);
    end
    step();
  endtask

  task automatic test_branch();
    for (int unsigned k = 0; k < 2; k++) begin
      drive(0, 1, $urandom, '0, 0, '0, 0, '0); step();
    end
    drive(0, 1, $urandom, '0, 0, '0, 1, 32'h400);
    total++;
    if (actv !== expv() || if_pc !== 32'h20) begin
      bad++; $display("FAIL branch_src actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h400) begin
      bad++; $display("FAIL branch_target actual=%h required=400", ibus_addr);
    end
    step();
  endtask

  task automatic test_flush();
    drive(0, 1, $urandom, '0, 1, 32'h30, 0, '0); step();
    drive(0, 0, $urandom, 6'b000011, 1, 32'h180, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h30 || stallreq_from_if !== 1'b1) begin
      bad++; $display("FAIL flush_pending actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 0, $urandom, 6'b000011, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h30 || ibus_req !== 1'b1 || if_inst !== '0) begin
      bad++; $display("FAIL flush_drop actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, 32'hbad0_0bad, 6'b000011, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h30 || if_inst !== '0) begin
      bad++; $display("FAIL flush_discard actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h180 || if_pc !== 32'h180) begin
      bad++; $display("FAIL flush_target actual=%h required=addr 00000180", actv);
    end
    step();
  endtask

  task automatic test_rst_mid();
    drive(0, 1, $urandom, '0, 1, 32'h40, 0, '0); step();
    drive(0, 0, $urandom, 6'b000011, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== 32'h40 || stallreq_from_if !== 1'b1) begin
      bad++; $display("FAIL rst_wait actual=%h required=%h", actv, expv());
    end
    step();
    drive(1, 0, $urandom, 6'b000011, 0, '0, 0, '0); step();
    drive(1, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || {ibus_req, ce, stallreq_from_if, if_pc, if_inst} !== 67'd0) begin
      bad++; $display("FAIL rst_mid actual=%h required=%h", actv, expv());
    end
    step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0); step();
    drive(0, 1, $urandom, '0, 0, '0, 0, '0);
    total++;
    if (actv !== expv() || ibus_addr !== RESET_PC || ibus_req !== 1'b1) begin
      bad++; $display("FAIL rst_refetch actual=%h required=%h", actv, expv());
    end
    step();
  endtask

  task automatic test_random();
    logic r, a, f, b;
    logic [5:0] st;
    for (int unsigned n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      a  = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 3) == 0) ? (6'($urandom) | 6'b000011) : 6'($urandom) & 6'b111100;
      f  = ($urandom_range(0, 11) == 0);
      b  = ($urandom_range(0, 5) == 0);
      drive(r, a, $urandom, st, f, $urandom, b, $urandom);
      total++;
      if (actv !== expv()) begin
        bad++; $display("FAIL random_%0d actual=%h required=%h", n, actv, expv());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_hold();
    test_branch();
    test_flush();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
